// File: rtl/cp0_access_ctrl.sv
// Sequencer that serialises exception entry, ERET and MTC0 into single-register
// CP0 transactions, with pipeline stall, flush and redirect generation.
module cp0_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_in_delay_slot,
  input  logic        exc_has_badvaddr,
  input  logic [31:0] exc_bad_vaddr,
  input  logic        eret_valid,
  input  logic        mtc0_valid,
  input  logic [7:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  input  logic [7:0]  mfc0_addr,
  input  logic [31:0] cp0_read_data,
  output logic [7:0]  cp0_read_addr,
  output logic        cp0_write_en,
  output logic [7:0]  cp0_write_addr,
  output logic [31:0] cp0_write_data,
  output logic        busy,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [7:0]  ADDR_STATUS = 8'h60;
  localparam logic [7:0]  ADDR_CAUSE  = 8'h68;
  localparam logic [7:0]  ADDR_EPC    = 8'h70;
  localparam logic [7:0]  ADDR_BADVA  = 8'h40;
  localparam logic [31:0] EXC_VECTOR  = 32'hBFC00380;

  typedef enum logic [3:0] {
    IDLE, EX_RD_ST, EX_WR_ST, EX_WR_CA, EX_WR_EPC, EX_WR_BV,
    ER_RD_EPC, ER_RD_ST, ER_WR_ST, MT_WR, DONE
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] pc_q, pc_d;
  logic        bd_q, bd_d;
  logic        hasbv_q, hasbv_d;
  logic [31:0] bv_q, bv_d;
  logic [7:0]  maddr_q, maddr_d;
  logic [31:0] mdata_q, mdata_d;
  logic        oexl_q, oexl_d;
  logic [31:0] tgt_q, tgt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      pc_q    <= '0;
      bd_q    <= 1'b0;
      hasbv_q <= 1'b0;
      bv_q    <= '0;
      maddr_q <= '0;
      mdata_q <= '0;
      oexl_q  <= 1'b0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
      bd_q    <= bd_d;
      hasbv_q <= hasbv_d;
      bv_q    <= bv_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      oexl_q  <= oexl_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    code_d         = code_q;
    pc_d           = pc_q;
    bd_d           = bd_q;
    hasbv_d        = hasbv_q;
    bv_d           = bv_q;
    maddr_d        = maddr_q;
    mdata_d        = mdata_q;
    oexl_d         = oexl_q;
    tgt_d          = tgt_q;
    cp0_read_addr  = mfc0_addr;
    cp0_write_en   = 1'b0;
    cp0_write_addr = '0;
    cp0_write_data = '0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    busy           = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (exc_valid) begin
          state_d = EX_RD_ST;
          code_d  = exc_code;
          pc_d    = exc_pc;
          bd_d    = exc_in_delay_slot;
          hasbv_d = exc_has_badvaddr;
          bv_d    = exc_bad_vaddr;
          tgt_d   = EXC_VECTOR;
        end else if (eret_valid) begin
          state_d = ER_RD_EPC;
        end else if (mtc0_valid) begin
          state_d = MT_WR;
          maddr_d = mtc0_addr;
          mdata_d = mtc0_data;
        end
      end
      EX_RD_ST: begin
        cp0_read_addr = ADDR_STATUS;
        state_d       = EX_WR_ST;
      end
      EX_WR_ST: begin
        // Cause is read here so its value lines up with the EX_WR_CA write.
        cp0_read_addr  = ADDR_CAUSE;
        cp0_write_en   = 1'b1;
        cp0_write_addr = ADDR_STATUS;
        cp0_write_data = cp0_read_data | 32'h2;
        oexl_d         = cp0_read_data[1];
        state_d        = EX_WR_CA;
      end
      EX_WR_CA: begin
        cp0_read_addr  = ADDR_CAUSE;
        cp0_write_en   = 1'b1;
        cp0_write_addr = ADDR_CAUSE;
        cp0_write_data = {(oexl_q ? cp0_read_data[31] : bd_q),
                          cp0_read_data[30:7], code_q, cp0_read_data[1:0]};
        if (!oexl_q)      state_d = EX_WR_EPC;
        else if (hasbv_q) state_d = EX_WR_BV;
        else              state_d = DONE;
      end
      EX_WR_EPC: begin
        cp0_read_addr  = ADDR_EPC;
        cp0_write_en   = 1'b1;
        cp0_write_addr = ADDR_EPC;
        cp0_write_data = bd_q ? (pc_q - 32'd4) : pc_q;
        state_d        = hasbv_q ? EX_WR_BV : DONE;
      end
      EX_WR_BV: begin
        cp0_read_addr  = ADDR_BADVA;
        cp0_write_en   = 1'b1;
        cp0_write_addr = ADDR_BADVA;
        cp0_write_data = bv_q;
        state_d        = DONE;
      end
      ER_RD_EPC: begin
        cp0_read_addr = ADDR_EPC;
        state_d       = ER_RD_ST;
      end
      ER_RD_ST: begin
        cp0_read_addr = ADDR_STATUS;
        tgt_d         = cp0_read_data;
        state_d       = ER_WR_ST;
      end
      ER_WR_ST: begin
        cp0_read_addr  = ADDR_STATUS;
        cp0_write_en   = 1'b1;
        cp0_write_addr = ADDR_STATUS;
        cp0_write_data = cp0_read_data & ~32'h2;
        state_d        = DONE;
      end
      MT_WR: begin
        cp0_write_en   = 1'b1;
        cp0_write_addr = maddr_q;
        cp0_write_data = mdata_q;
        state_d        = IDLE;
      end
      DONE: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = tgt_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cp0_access_ctrl.sv
// Directed bench for cp0_access_ctrl against a small CP0 register-file model
// with registered reads.
module tb_cp0_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_in_delay_slot;
  logic        exc_has_badvaddr;
  logic [31:0] exc_bad_vaddr;
  logic        eret_valid;
  logic        mtc0_valid;
  logic [7:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic [7:0]  mfc0_addr;
  logic [31:0] cp0_read_data;
  logic [7:0]  cp0_read_addr;
  logic        cp0_write_en;
  logic [7:0]  cp0_write_addr;
  logic [31:0] cp0_write_data;
  logic        busy;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  always #5 clk = ~clk;

  cp0_access_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .exc_valid         (exc_valid),
    .exc_code          (exc_code),
    .exc_pc            (exc_pc),
    .exc_in_delay_slot (exc_in_delay_slot),
    .exc_has_badvaddr  (exc_has_badvaddr),
    .exc_bad_vaddr     (exc_bad_vaddr),
    .eret_valid        (eret_valid),
    .mtc0_valid        (mtc0_valid),
    .mtc0_addr         (mtc0_addr),
    .mtc0_data         (mtc0_data),
    .mfc0_addr         (mfc0_addr),
    .cp0_read_data     (cp0_read_data),
    .cp0_read_addr     (cp0_read_addr),
    .cp0_write_en      (cp0_write_en),
    .cp0_write_addr    (cp0_write_addr),
    .cp0_write_data    (cp0_write_data),
    .busy              (busy),
    .flush             (flush),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc)
  );

  always @(posedge clk) begin
    cp0_read_data <= mem[cp0_read_addr];
    if (pre_we)            mem[pre_addr] <= pre_data;
    else if (cp0_write_en) mem[cp0_write_addr] <= cp0_write_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string t, input logic b, input logic we, input logic [7:0] wa,
                     input logic [31:0] wd, input logic fl, input logic [31:0] rpc);
    chk({t, ".busy"}, {31'd0, busy}, {31'd0, b});
    chk({t, ".we"}, {31'd0, cp0_write_en}, {31'd0, we});
    chk({t, ".waddr"}, {24'd0, cp0_write_addr}, {24'd0, wa});
    chk({t, ".wdata"}, cp0_write_data, wd);
    chk({t, ".flush"}, {31'd0, flush}, {31'd0, fl});
    chk({t, ".rvalid"}, {31'd0, redirect_valid}, {31'd0, fl});
    chk({t, ".rpc"}, redirect_pc, rpc);
  endtask

  task automatic pre(input logic [7:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic set_exc(input logic [4:0] c, input logic [31:0] pc, input logic bd,
                         input logic hbv, input logic [31:0] bv);
    exc_code = c; exc_pc = pc; exc_in_delay_slot = bd;
    exc_has_badvaddr = hbv; exc_bad_vaddr = bv; exc_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1; exc_valid = 0; exc_code = '0; exc_pc = '0; exc_in_delay_slot = 0;
    exc_has_badvaddr = 0; exc_bad_vaddr = '0; eret_valid = 0; mtc0_valid = 0;
    mtc0_addr = '0; mtc0_data = '0; mfc0_addr = 8'h78;
    tick(); tick();
    cyc("rst", 0, 0, 8'h00, 32'h0, 0, 32'h0);
    chk("rst.raddr", {24'd0, cp0_read_addr}, 32'h78);
    rst = 1'b0;

    // Full exception path
    pre(8'h60, 32'h0); pre(8'h68, 32'h0); pre(8'h70, 32'h0); pre(8'h40, 32'h0);
    set_exc(5'h04, 32'hBFC00100, 1'b0, 1'b1, 32'h00000003);
    tick(); exc_valid = 1'b0;
    chk("e1c1.raddr", {24'd0, cp0_read_addr}, 32'h60);
    cyc("e1c1", 1, 0, 8'h00, 32'h0, 0, 32'h0);
    tick(); cyc("e1c2", 1, 1, 8'h60, 32'h00000002, 0, 32'h0);
    tick(); cyc("e1c3", 1, 1, 8'h68, 32'h00000010, 0, 32'h0);
    tick(); cyc("e1c4", 1, 1, 8'h70, 32'hBFC00100, 0, 32'h0);
    tick(); cyc("e1c5", 1, 1, 8'h40, 32'h00000003, 0, 32'h0);
    tick(); cyc("e1c6", 1, 0, 8'h00, 32'h0, 1, 32'hBFC00380);
    tick(); cyc("e1c7", 0, 0, 8'h00, 32'h0, 0, 32'h0);
    chk("e1.raddr_idle", {24'd0, cp0_read_addr}, 32'h78);
    chk("e1.mem_st", mem[8'h60], 32'h2);
    chk("e1.mem_ca", mem[8'h68], 32'h10);

    // Delay-slot exception, no BadVAddr
    pre(8'h60, 32'h0); pre(8'h68, 32'h0); pre(8'h40, 32'hDEAD0000);
    set_exc(5'h08, 32'h80000010, 1'b1, 1'b0, 32'h12345678);
    tick(); exc_valid = 1'b0;
    cyc("e2c1", 1, 0, 8'h00, 32'h0, 0, 32'h0);
    tick(); cyc("e2c2", 1, 1, 8'h60, 32'h00000002, 0, 32'h0);
    tick(); cyc("e2c3", 1, 1, 8'h68, 32'h80000020, 0, 32'h0);
    tick(); cyc("e2c4", 1, 1, 8'h70, 32'h8000000C, 0, 32'h0);
    tick(); cyc("e2c5", 1, 0, 8'h00, 32'h0, 1, 32'hBFC00380);
    tick(); cyc("e2c6", 0, 0, 8'h00, 32'h0, 0, 32'h0);
    chk("e2.mem_bv", mem[8'h40], 32'hDEAD0000);
    chk("e2.mem_epc", mem[8'h70], 32'h8000000C);

    // Nested exception: EPC untouched, BD bit kept
    pre(8'h60, 32'h2); pre(8'h68, 32'h80000000); pre(8'h70, 32'h11112222);
    set_exc(5'h0C, 32'h80000400, 1'b0, 1'b0, 32'h0);
    tick(); exc_valid = 1'b0;
    cyc("e3c1", 1, 0, 8'h00, 32'h0, 0, 32'h0);
    tick(); cyc("e3c2", 1, 1, 8'h60, 32'h00000002, 0, 32'h0);
    tick(); cyc("e3c3", 1, 1, 8'h68, 32'h80000030, 0, 32'h0);
    tick(); cyc("e3c4", 1, 0, 8'h00, 32'h0, 1, 32'hBFC00380);
    tick(); cyc("e3c5", 0, 0, 8'h00, 32'h0, 0, 32'h0);
    chk("e3.mem_epc", mem[8'h70], 32'h11112222);

    // ERET
    pre(8'h70, 32'h80001234); pre(8'h60, 32'h3);
    eret_valid = 1'b1;
    tick(); eret_valid = 1'b0;
    chk("r1c1.raddr", {24'd0, cp0_read_addr}, 32'h70);
    cyc("r1c1", 1, 0, 8'h00, 32'h0, 0, 32'h0);
    tick();
    chk("r1c2.raddr", {24'd0, cp0_read_addr}, 32'h60);
    cyc("r1c2", 1, 0, 8'h00, 32'h0, 0, 32'h0);
    tick(); cyc("r1c3", 1, 1, 8'h60, 32'h00000001, 0, 32'h0);
    tick(); cyc("r1c4", 1, 0, 8'h00, 32'h0, 1, 32'h80001234);
    tick(); cyc("r1c5", 0, 0, 8'h00, 32'h0, 0, 32'h0);
    chk("r1.mem_st", mem[8'h60], 32'h1);

    // Simultaneous requests; eret/mtc0 held through the busy window
    pre(8'h60, 32'h0); pre(8'h68, 32'h0); pre(8'h58, 32'h0);
    set_exc(5'h01, 32'h80000100, 1'b0, 1'b0, 32'h0);
    eret_valid = 1'b1; mtc0_valid = 1'b1; mtc0_addr = 8'h58; mtc0_data = 32'hCAFEBABE;
    tick(); exc_valid = 1'b0;
    chk("p1c1.raddr", {24'd0, cp0_read_addr}, 32'h60);
    cyc("p1c1", 1, 0, 8'h00, 32'h0, 0, 32'h0);
    tick(); cyc("p1c2", 1, 1, 8'h60, 32'h00000002, 0, 32'h0);
    tick(); cyc("p1c3", 1, 1, 8'h68, 32'h00000004, 0, 32'h0);
    tick(); cyc("p1c4", 1, 1, 8'h70, 32'h80000100, 0, 32'h0);
    eret_valid = 1'b0; mtc0_valid = 1'b0;
    tick(); cyc("p1c5", 1, 0, 8'h00, 32'h0, 1, 32'hBFC00380);
    tick(); cyc("p1c6", 0, 0, 8'h00, 32'h0, 0, 32'h0);
    chk("p1.mem_mt", mem[8'h58], 32'h0);

    // MTC0
    mtc0_valid = 1'b1; mtc0_addr = 8'h60; mtc0_data = 32'h0000FF01;
    tick(); mtc0_valid = 1'b0;
    cyc("m1c1", 1, 1, 8'h60, 32'h0000FF01, 0, 32'h0);
    tick(); cyc("m1c2", 0, 0, 8'h00, 32'h0, 0, 32'h0);
    chk("m1.mem_st", mem[8'h60], 32'h0000FF01);

    // Reset during EX_WR_CA
    pre(8'h70, 32'h55555555); pre(8'h40, 32'h0);
    set_exc(5'h04, 32'h80000800, 1'b0, 1'b1, 32'h00000077);
    tick(); exc_valid = 1'b0;
    tick();
    tick(); cyc("x1c3", 1, 1, 8'h68, 32'h00000010, 0, 32'h0);
    rst = 1'b1;
    tick(); cyc("x1rst", 0, 0, 8'h00, 32'h0, 0, 32'h0);
    chk("x1rst.raddr", {24'd0, cp0_read_addr}, 32'h78);
    rst = 1'b0;
    tick(); cyc("x1a", 0, 0, 8'h00, 32'h0, 0, 32'h0);
    tick(); cyc("x1b", 0, 0, 8'h00, 32'h0, 0, 32'h0);
    tick(); cyc("x1c", 0, 0, 8'h00, 32'h0, 0, 32'h0);
    chk("x1.mem_epc", mem[8'h70], 32'h55555555);
    chk("x1.mem_bv", mem[8'h40], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
